// File: rtl/reset_seq_ctrl_if.sv
// Reset-sequencer handshake bundle: request/ready inputs and sequenced reset outputs.
// master = firmware/SoC side driving requests, slave = the sequencer itself.
interface reset_seq_ctrl_if #(
    parameter int N_DOM = 4
) ();
    logic             sw_rst_req;
    logic             wdt_rst_req;
    logic [N_DOM-1:0] dom_rdy;
    logic             cause_clr;
    logic [N_DOM-1:0] dom_rst_n;
    logic             rst_done;
    logic [2:0]       rst_cause;
    logic [N_DOM-1:0] tmo_err;

    modport master (
        output sw_rst_req, wdt_rst_req, dom_rdy, cause_clr,
        input  dom_rst_n, rst_done, rst_cause, tmo_err
    );

    modport slave (
        input  sw_rst_req, wdt_rst_req, dom_rdy, cause_clr,
        output dom_rst_n, rst_done, rst_cause, tmo_err
    );
endinterface

// File: rtl/reset_seq_ctrl.sv
// SoC domain reset sequencer: hold all domains, then release them one by one in index
// order, each gated by its ready input with a timeout; records a sticky reset cause.
module reset_seq_ctrl #(
    parameter int N_DOM    = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 4,
    parameter int TMO_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst,
    reset_seq_ctrl_if.slave  bus
);
    localparam int MAX_HG   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_ALL  = (MAX_HG > TMO_CYC) ? MAX_HG : TMO_CYC;
    localparam int CNT_W    = $clog2(MAX_ALL + 1);
    localparam int STG_W    = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int GAP_LAST_I = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [STG_W-1:0] LAST_STG  = STG_W'(N_DOM - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_RUN
    } state_t;

    state_t             state,     state_nxt;
    logic [CNT_W-1:0]   cnt,       cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [STG_W-1:0]   stage,     stage_nxt;
    logic [N_DOM-1:0]   rel_q,     rel_nxt;
    logic               done_q,    done_nxt;
    logic [2:0]         cause_q,   cause_nxt;
    logic [N_DOM-1:0]   tmo_q,     tmo_nxt;
    logic               req;
    logic [2:0]         req_bits;

    assign req      = bus.sw_rst_req | bus.wdt_rst_req;
    assign req_bits = {bus.wdt_rst_req, bus.sw_rst_req, 1'b0};
    assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        stage_nxt = stage;
        rel_nxt   = rel_q;
        done_nxt  = done_q;
        cause_nxt = cause_q;
        tmo_nxt   = tmo_q;

        case (state)
            S_HOLD: begin
                rel_nxt  = '0;
                done_nxt = 1'b0;
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_WAIT: begin
                if (bus.dom_rdy[stage] || (cnt == TMO_LAST)) begin
                    rel_nxt[stage] = 1'b1;
                    if (!bus.dom_rdy[stage])
                        tmo_nxt[stage] = 1'b1;
                    cnt_nxt = '0;
                    if (stage == LAST_STG) begin
                        state_nxt = S_RUN;
                        done_nxt  = 1'b1;
                    end else if (GAP_CYC == 0) begin
                        stage_nxt = stage + STG_W'(1);
                    end else begin
                        state_nxt = S_GAP;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                    stage_nxt = stage + STG_W'(1);
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_RUN: begin
                if (bus.cause_clr) begin
                    cause_nxt = '0;
                    tmo_nxt   = '0;
                end
            end
            default: state_nxt = S_HOLD;
        endcase

        // A reset request overrides everything, including a same-edge cause_clr.
        if (req) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
            stage_nxt = '0;
            rel_nxt   = '0;
            done_nxt  = 1'b0;
            if (state == S_RUN) begin
                cause_nxt = req_bits;
                tmo_nxt   = '0;
            end else begin
                cause_nxt = cause_q | req_bits;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state   <= S_HOLD;
            cnt     <= '0;
            stage   <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= 3'b001;
            tmo_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stage   <= stage_nxt;
            rel_q   <= rel_nxt;
            done_q  <= done_nxt;
            cause_q <= cause_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    assign bus.dom_rst_n = rel_q;
    assign bus.rst_done  = done_q;
    assign bus.rst_cause = cause_q;
    assign bus.tmo_err   = tmo_q;
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with default parameters; edge numbers are counted
// from the edge after rst falls (or from the reset-request edge).
module tb_reset_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n  = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   rise_e [4];
    int   done_e;
    bit   order_bad;

    reset_seq_ctrl_if #(.N_DOM(4)) bus ();

    reset_seq_ctrl #(
        .N_DOM(4), .HOLD_CYC(16), .GAP_CYC(4), .TMO_CYC(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_por(input logic [3:0] rdy);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dom_rdy = rdy;
        edge_n = 0;
    endtask

    // Steps until rst_done or budget, recording the edge where each dom_rst_n bit rose.
    task automatic watch(input int budget, input int late_dom, input int late_edge);
        for (int i = 0; i < 4; i++) rise_e[i] = -1;
        done_e    = -1;
        order_bad = 1'b0;
        for (int k = 0; k < budget && done_e < 0; k++) begin
            if (late_dom >= 0 && edge_n == late_edge - 1) bus.dom_rdy[late_dom] = 1'b1;
            tick();
            for (int i = 0; i < 4; i++)
                if (rise_e[i] < 0 && bus.dom_rst_n[i]) rise_e[i] = edge_n;
            for (int i = 1; i < 4; i++)
                if (bus.dom_rst_n[i] && !bus.dom_rst_n[i-1]) order_bad = 1'b1;
            if (bus.rst_done) done_e = edge_n;
        end
    endtask

    task automatic test_reset();
        bus.sw_rst_req = 1'b1;
        tick();
        tick();
        bus.sw_rst_req = 1'b0;
        n_total++; if (bus.dom_rst_n !== 4'h0) $display("FAIL reset dom_rst_n got %h want 0", bus.dom_rst_n); else n_pass++;
        n_total++; if (bus.rst_done !== 1'b0) $display("FAIL reset rst_done got %b want 0", bus.rst_done); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b001) $display("FAIL reset rst_cause got %b want 001", bus.rst_cause); else n_pass++;
        n_total++; if (bus.tmo_err !== 4'h0) $display("FAIL reset tmo_err got %h want 0", bus.tmo_err); else n_pass++;
    endtask

    task automatic test_por();
        int exp_r [4] = '{17, 22, 27, 32};
        do_por(4'hF);
        watch(60, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rise_e[i] !== exp_r[i]) $display("FAIL por rise[%0d] got %0d want %0d", i, rise_e[i], exp_r[i]); else n_pass++;
        end
        n_total++; if (done_e !== 32) $display("FAIL por done_edge got %0d want 32", done_e); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b001) $display("FAIL por rst_cause got %b want 001", bus.rst_cause); else n_pass++;
        n_total++; if (bus.tmo_err !== 4'h0) $display("FAIL por tmo_err got %h want 0", bus.tmo_err); else n_pass++;
        n_total++; if (order_bad !== 1'b0) $display("FAIL por order got %b want 0", order_bad); else n_pass++;
    endtask

    task automatic test_wdt_run();
        bus.wdt_rst_req = 1'b1;
        tick();
        bus.wdt_rst_req = 1'b0;
        n_total++; if (bus.dom_rst_n !== 4'h0) $display("FAIL wdt dom_rst_n got %h want 0", bus.dom_rst_n); else n_pass++;
        n_total++; if (bus.rst_done !== 1'b0) $display("FAIL wdt rst_done got %b want 0", bus.rst_done); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b100) $display("FAIL wdt rst_cause got %b want 100", bus.rst_cause); else n_pass++;
        edge_n = 0;
        watch(60, -1, 0);
        n_total++; if (rise_e[0] !== 17) $display("FAIL wdt rise[0] got %0d want 17", rise_e[0]); else n_pass++;
        n_total++; if (done_e !== 32) $display("FAIL wdt done_edge got %0d want 32", done_e); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b100) $display("FAIL wdt cause_after got %b want 100", bus.rst_cause); else n_pass++;
    endtask

    task automatic test_cause_clr();
        bus.cause_clr  = 1'b1;
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        n_total++; if (bus.rst_cause !== 3'b010) $display("FAIL clr_req rst_cause got %b want 010", bus.rst_cause); else n_pass++;
        n_total++; if (bus.rst_done !== 1'b0) $display("FAIL clr_req rst_done got %b want 0", bus.rst_done); else n_pass++;
        edge_n = 0;
        tick();
        bus.cause_clr = 1'b0;
        n_total++; if (bus.rst_cause !== 3'b010) $display("FAIL clr_hold rst_cause got %b want 010", bus.rst_cause); else n_pass++;
        watch(60, -1, 0);
        n_total++; if (done_e !== 32) $display("FAIL clr done_edge got %0d want 32", done_e); else n_pass++;
        bus.cause_clr = 1'b1;
        tick();
        bus.cause_clr = 1'b0;
        n_total++; if (bus.rst_cause !== 3'b000) $display("FAIL clr_run rst_cause got %b want 000", bus.rst_cause); else n_pass++;
        n_total++; if (bus.dom_rst_n !== 4'hF) $display("FAIL clr_run dom_rst_n got %h want F", bus.dom_rst_n); else n_pass++;
        n_total++; if (bus.rst_done !== 1'b1) $display("FAIL clr_run rst_done got %b want 1", bus.rst_done); else n_pass++;
    endtask

    task automatic test_rdy_late();
        int exp_r [4] = '{17, 31, 36, 41};
        do_por(4'b1101);
        watch(100, 1, 31);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rise_e[i] !== exp_r[i]) $display("FAIL late rise[%0d] got %0d want %0d", i, rise_e[i], exp_r[i]); else n_pass++;
        end
        n_total++; if (done_e !== 41) $display("FAIL late done_edge got %0d want 41", done_e); else n_pass++;
        n_total++; if (bus.tmo_err !== 4'h0) $display("FAIL late tmo_err got %h want 0", bus.tmo_err); else n_pass++;
    endtask

    task automatic test_timeout();
        int exp_r [4] = '{17, 22, 90, 95};
        do_por(4'b1011);
        watch(150, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rise_e[i] !== exp_r[i]) $display("FAIL tmo rise[%0d] got %0d want %0d", i, rise_e[i], exp_r[i]); else n_pass++;
        end
        n_total++; if (done_e !== 95) $display("FAIL tmo done_edge got %0d want 95", done_e); else n_pass++;
        n_total++; if (bus.tmo_err !== 4'b0100) $display("FAIL tmo tmo_err got %b want 0100", bus.tmo_err); else n_pass++;
        n_total++; if (order_bad !== 1'b0) $display("FAIL tmo order got %b want 0", order_bad); else n_pass++;
        bus.dom_rdy = 4'h0;
        tick();
        tick();
        n_total++; if (bus.dom_rst_n !== 4'hF) $display("FAIL rdy_drop dom_rst_n got %h want F", bus.dom_rst_n); else n_pass++;
    endtask

    task automatic test_mid_wait_rst();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        n_total++; if (bus.rst_cause !== 3'b010) $display("FAIL sw_run rst_cause got %b want 010", bus.rst_cause); else n_pass++;
        n_total++; if (bus.tmo_err !== 4'h0) $display("FAIL sw_run tmo_err got %h want 0", bus.tmo_err); else n_pass++;
        edge_n = 0;
        bus.dom_rdy = 4'b0001;
        for (int k = 0; k < 25; k++) tick();
        n_total++; if (bus.dom_rst_n !== 4'b0001) $display("FAIL midwait dom_rst_n got %b want 0001", bus.dom_rst_n); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (bus.dom_rst_n !== 4'h0) $display("FAIL midrst dom_rst_n got %h want 0", bus.dom_rst_n); else n_pass++;
        n_total++; if (bus.rst_done !== 1'b0) $display("FAIL midrst rst_done got %b want 0", bus.rst_done); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b001) $display("FAIL midrst rst_cause got %b want 001", bus.rst_cause); else n_pass++;
    endtask

    task automatic test_sw_in_gap();
        do_por(4'hF);
        for (int k = 0; k < 18; k++) tick();
        n_total++; if (bus.dom_rst_n !== 4'b0001) $display("FAIL gap dom_rst_n got %b want 0001", bus.dom_rst_n); else n_pass++;
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        n_total++; if (bus.dom_rst_n !== 4'h0) $display("FAIL gap_req dom_rst_n got %h want 0", bus.dom_rst_n); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b011) $display("FAIL gap_req rst_cause got %b want 011", bus.rst_cause); else n_pass++;
        edge_n = 0;
        watch(60, -1, 0);
        n_total++; if (rise_e[0] !== 17) $display("FAIL gap rise[0] got %0d want 17", rise_e[0]); else n_pass++;
        n_total++; if (done_e !== 32) $display("FAIL gap done_edge got %0d want 32", done_e); else n_pass++;
        n_total++; if (bus.rst_cause !== 3'b011) $display("FAIL gap cause_after got %b want 011", bus.rst_cause); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.sw_rst_req  = 1'b1;
        bus.wdt_rst_req = 1'b1;
        tick();
        bus.sw_rst_req  = 1'b0;
        bus.wdt_rst_req = 1'b0;
        n_total++; if (bus.rst_cause !== 3'b110) $display("FAIL both rst_cause got %b want 110", bus.rst_cause); else n_pass++;
        n_total++; if (bus.dom_rst_n !== 4'h0) $display("FAIL both dom_rst_n got %h want 0", bus.dom_rst_n); else n_pass++;
        edge_n = 0;
        watch(60, -1, 0);
        n_total++; if (done_e !== 32) $display("FAIL both done_edge got %0d want 32", done_e); else n_pass++;
    endtask

    initial begin
        bus.sw_rst_req  = 1'b0;
        bus.wdt_rst_req = 1'b0;
        bus.cause_clr   = 1'b0;
        bus.dom_rdy     = 4'h0;
        test_reset();
        test_por();
        test_wdt_run();
        test_cause_clr();
        test_rdy_late();
        test_timeout();
        test_mid_wait_rst();
        test_sw_in_gap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got time %0t want finish earlier", $time);
        $fatal(1);
    end
endmodule
